// File: rtl/ol_sequencer_if.sv
// Object-list sequencer bus bundle: control, parser handshake and shared
// VRAM port. The error flag exists only when OL_WATCHDOG_EN is defined.
// master = sequencer side, slave = environment (parser, VRAM, host).
interface ol_sequencer_if;
    logic        start;
    logic        abort;
    logic [23:0] ol_base;
    logic [23:0] param_base;
    logic        busy;
    logic        done;
    logic [31:0] opb_word;
    logic [23:0] poly_addr;
    logic        render_poly;
    logic        poly_drawn;
    logic        isp_vram_rd;
    logic        isp_vram_wr;
    logic [23:0] isp_vram_addr;
    logic [31:0] isp_vram_dout;
    logic        vram_rd;
    logic        vram_wr;
    logic [23:0] vram_addr;
    logic [31:0] vram_dout;
    logic [31:0] vram_din;
    logic [15:0] poly_count;
`ifdef OL_WATCHDOG_EN
    logic        error;
`endif

    modport master (
        input  start, abort, ol_base, param_base, poly_drawn,
               isp_vram_rd, isp_vram_wr, isp_vram_addr, isp_vram_dout, vram_din,
        output busy, done, opb_word, poly_addr, render_poly,
               vram_rd, vram_wr, vram_addr, vram_dout, poly_count
`ifdef OL_WATCHDOG_EN
        , output error
`endif
    );

    modport slave (
        output start, abort, ol_base, param_base, poly_drawn,
               isp_vram_rd, isp_vram_wr, isp_vram_addr, isp_vram_dout, vram_din,
        input  busy, done, opb_word, poly_addr, render_poly,
               vram_rd, vram_wr, vram_addr, vram_dout, poly_count
`ifdef OL_WATCHDOG_EN
        , input error
`endif
    );
endinterface

// File: rtl/ol_sequencer.sv
// Object-list sequencer: walks an object list in VRAM, hands each
// primitive's parameter address to the parser and waits for completion.
// Optional macro OL_WATCHDOG_EN adds a fetch-count watchdog and error flag.
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | waiting for start
// FETCH       | vram_rd issued at ol_addr
// WAIT        | read data returning, latched into opb_word
// DECODE      | classify opb_word: primitive / EOL / link / skip
// RENDER      | render_poly pulse, primitive counted
// WAIT_DRAWN  | parser owns VRAM, waiting for poly_drawn
module ol_sequencer (
    input  logic            clock,
    input  logic            reset_n,
    ol_sequencer_if.master  bus
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_WAIT       = 3'd2;
    localparam logic [2:0] ST_DECODE     = 3'd3;
    localparam logic [2:0] ST_RENDER     = 3'd4;
    localparam logic [2:0] ST_WAIT_DRAWN = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [23:0] ol_addr_q, ol_addr_d;
    logic [31:0] opb_word_q, opb_word_d;
    logic [23:0] poly_addr_q, poly_addr_d;
    logic [15:0] poly_count_q, poly_count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        drawn_pend_q, drawn_pend_d;

    logic        is_poly, is_eol, is_link;
    logic        wd_trip;
    logic        parser_owns;

`ifdef OL_WATCHDOG_EN
    logic [11:0] wd_cnt_q, wd_cnt_d;
    logic        error_q, error_d;
    assign wd_trip = (wd_cnt_q == 12'hFFF);
`else
    assign wd_trip = 1'b0;
`endif

    // Word type classification from the latched OL word
    always_comb begin
        is_poly = !opb_word_q[31] || (opb_word_q[31:29] == 3'b100) || (opb_word_q[31:29] == 3'b101);
        is_eol  = (opb_word_q[31:29] == 3'b111) &&  opb_word_q[28];
        is_link = (opb_word_q[31:29] == 3'b111) && !opb_word_q[28];
    end

    // Next-state logic; abort overrides every state
    always_comb begin
        state_d      = state_q;
        ol_addr_d    = ol_addr_q;
        opb_word_d   = opb_word_q;
        poly_addr_d  = poly_addr_q;
        poly_count_d = poly_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        drawn_pend_d = drawn_pend_q;
`ifdef OL_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        error_d      = error_q;
`endif
        if (bus.abort) begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            drawn_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        ol_addr_d    = bus.ol_base;
                        poly_count_d = 16'd0;
                        busy_d       = 1'b1;
                        state_d      = ST_FETCH;
`ifdef OL_WATCHDOG_EN
                        wd_cnt_d     = 12'd0;
                        error_d      = 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    state_d = ST_WAIT;
`ifdef OL_WATCHDOG_EN
                    if (wd_cnt_q != 12'hFFF) wd_cnt_d = wd_cnt_q + 12'd1;
`endif
                end
                ST_WAIT: begin
                    opb_word_d = bus.vram_din;
                    state_d    = ST_DECODE;
                end
                ST_DECODE: begin
                    if (wd_trip) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
`ifdef OL_WATCHDOG_EN
                        error_d = 1'b1;
`endif
                    end else if (is_poly) begin
                        // parameter offset is in words; 24-bit sum wraps
                        poly_addr_d = bus.param_base + {1'b0, opb_word_q[20:0], 2'b00};
                        state_d     = ST_RENDER;
                    end else if (is_eol) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (is_link) begin
                        ol_addr_d = {opb_word_q[23:2], 2'b00};
                        state_d   = ST_FETCH;
                    end else begin
                        ol_addr_d = ol_addr_q + 24'd4;
                        state_d   = ST_FETCH;
                    end
                end
                ST_RENDER: begin
                    if (poly_count_q != 16'hFFFF) poly_count_d = poly_count_q + 16'd1;
                    // a completion arriving with render_poly is held for WAIT_DRAWN
                    drawn_pend_d = bus.poly_drawn;
                    state_d      = ST_WAIT_DRAWN;
                end
                ST_WAIT_DRAWN: begin
                    if (bus.poly_drawn || drawn_pend_q) begin
                        drawn_pend_d = 1'b0;
                        ol_addr_d    = ol_addr_q + 24'd4;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ol_addr_q    <= 24'd0;
            opb_word_q   <= 32'd0;
            poly_addr_q  <= 24'd0;
            poly_count_q <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drawn_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ol_addr_q    <= ol_addr_d;
            opb_word_q   <= opb_word_d;
            poly_addr_q  <= poly_addr_d;
            poly_count_q <= poly_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drawn_pend_q <= drawn_pend_d;
        end
    end

`ifdef OL_WATCHDOG_EN
    // Watchdog fetch counter and sticky error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= 12'd0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end
    assign bus.error = error_q;
`endif

    // VRAM port mux: parser owns it while a primitive is in flight
    always_comb begin
        parser_owns = ((state_q == ST_RENDER) || (state_q == ST_WAIT_DRAWN)) && !bus.abort;
        if (parser_owns) begin
            bus.vram_rd   = bus.isp_vram_rd;
            bus.vram_wr   = bus.isp_vram_wr;
            bus.vram_addr = bus.isp_vram_addr;
            bus.vram_dout = bus.isp_vram_dout;
        end else begin
            bus.vram_rd   = (state_q == ST_FETCH) && !bus.abort;
            bus.vram_wr   = 1'b0;
            bus.vram_addr = ol_addr_q;
            bus.vram_dout = 32'd0;
        end
    end

    assign bus.render_poly = (state_q == ST_RENDER) && !bus.abort;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.opb_word    = opb_word_q;
    assign bus.poly_addr   = poly_addr_q;
    assign bus.poly_count  = poly_count_q;

endmodule
